// File: rtl/bsg_muxi2_sched_pkg.sv
// rtl/bsg_muxi2_sched_pkg.sv - shared types and constants for the bsg_muxi2 scheduler
package bsg_muxi2_sched_pkg;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } bsg_muxi2_sched_state_e;

  typedef logic bsg_muxi2_sched_id_t;

  localparam int stats_width_lp = 32;

endpackage

// File: rtl/bsg_muxi2_gatestack.sv
// rtl/bsg_muxi2_gatestack.sv - per-bit inverting 2:1 mux, o = ~(i2 ? i1 : i0)
module bsg_muxi2_gatestack #(
  parameter int width_p = 64
) (
  input  logic [width_p-1:0] i0,
  input  logic [width_p-1:0] i1,
  input  logic [width_p-1:0] i2,
  output logic [width_p-1:0] o
);

  assign o = ~((i2 & i1) | (~i2 & i0));

endmodule

// File: rtl/bsg_muxi2_sched.sv
// rtl/bsg_muxi2_sched.sv - two-requester round-robin scheduler over bsg_muxi2_gatestack; optional BSG_MUXI2_SCHED_STATS_EN adds beat counters
module bsg_muxi2_sched
  import bsg_muxi2_sched_pkg::*;
#(
  parameter int width_p        = 64,
  parameter bit pos_polarity_p = 1'b1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                v0_i,
  input  logic [width_p-1:0]  data0_i,
  output logic                ready0_o,
  input  logic                v1_i,
  input  logic [width_p-1:0]  data1_i,
  output logic                ready1_o,
  input  logic                lock_i,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  output bsg_muxi2_sched_id_t src_o,
  input  logic                ready_i
`ifdef BSG_MUXI2_SCHED_STATS_EN
  ,
  output logic [stats_width_lp-1:0] count0_o,
  output logic [stats_width_lp-1:0] count1_o
`endif
);

  bsg_muxi2_sched_state_e state_q;
  logic                   owner_q;
  logic                   last_q;
  logic                   acc;
  logic                   gnt1;
  logic                   fire;
  logic [width_p-1:0]     gs_i0;
  logic [width_p-1:0]     gs_i1;
  logic [width_p-1:0]     gs_o;

  assign acc = ~v_o | ready_i;

  // With nobody valid the grant parks on ~last so the idle side may see ready.
  always_comb begin
    gnt1 = ~last_q;
    if (state_q == LOCKED) begin
      gnt1 = owner_q;
    end else if (v0_i & v1_i) begin
      gnt1 = ~last_q;
    end else if (v1_i) begin
      gnt1 = 1'b1;
    end else if (v0_i) begin
      gnt1 = 1'b0;
    end
  end

  assign ready0_o = acc & ~gnt1;
  assign ready1_o = acc & gnt1;
  assign fire     = acc & (gnt1 ? v1_i : v0_i);

  // Pre-inverting cancels the gatestack's inversion so data_o carries true data.
  assign gs_i0 = pos_polarity_p ? ~data0_i : data0_i;
  assign gs_i1 = pos_polarity_p ? ~data1_i : data1_i;

  bsg_muxi2_gatestack #(.width_p(width_p)) gatestack (
    .i0(gs_i0),
    .i1(gs_i1),
    .i2({width_p{gnt1}}),
    .o (gs_o)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_o     <= 1'b0;
      data_o  <= '0;
      src_o   <= 1'b0;
      last_q  <= 1'b1;
      state_q <= UNLOCKED;
      owner_q <= 1'b0;
    end else if (fire) begin
      v_o    <= 1'b1;
      data_o <= gs_o;
      src_o  <= gnt1;
      last_q <= gnt1;
      if (state_q == UNLOCKED && lock_i) begin
        state_q <= LOCKED;
        owner_q <= gnt1;
      end else if (state_q == LOCKED && !lock_i) begin
        state_q <= UNLOCKED;
      end
    end else if (ready_i) begin
      v_o <= 1'b0;
    end
  end

`ifdef BSG_MUXI2_SCHED_STATS_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count0_o <= '0;
      count1_o <= '0;
    end else if (fire) begin
      if (!gnt1 && count0_o != '1) count0_o <= count0_o + stats_width_lp'(1);
      if (gnt1 && count1_o != '1)  count1_o <= count1_o + stats_width_lp'(1);
    end
  end
`endif

endmodule

// File: tb/tb_bsg_muxi2_sched.sv
// tb/tb_bsg_muxi2_sched.sv - self-checking bench for bsg_muxi2_sched against a behavioural model
module tb_bsg_muxi2_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0, lk = 1'b0, rdy = 1'b0;
  logic [63:0] d0 = '0, d1 = '0;
  logic        r0, r1, vo, src;
  logic        nr0, nr1, nvo, nsrc;
  logic [63:0] dout, ndout;
`ifdef BSG_MUXI2_SCHED_STATS_EN
  logic [31:0] c0, c1, nc0, nc1;
`endif

  bsg_muxi2_sched #(.width_p(64), .pos_polarity_p(1'b1)) dut (
    .clk_i(clk), .reset_i(rst),
    .v0_i(v0), .data0_i(d0), .ready0_o(r0),
    .v1_i(v1), .data1_i(d1), .ready1_o(r1),
    .lock_i(lk), .v_o(vo), .data_o(dout), .src_o(src), .ready_i(rdy)
`ifdef BSG_MUXI2_SCHED_STATS_EN
    , .count0_o(c0), .count1_o(c1)
`endif
  );

  bsg_muxi2_sched #(.width_p(64), .pos_polarity_p(1'b0)) dut_n (
    .clk_i(clk), .reset_i(rst),
    .v0_i(v0), .data0_i(d0), .ready0_o(nr0),
    .v1_i(v1), .data1_i(d1), .ready1_o(nr1),
    .lock_i(lk), .v_o(nvo), .data_o(ndout), .src_o(nsrc), .ready_i(rdy)
`ifdef BSG_MUXI2_SCHED_STATS_EN
    , .count0_o(nc0), .count1_o(nc1)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: the packet lock, round-robin memory and the one-entry output slot.
  bit          m_locked, m_owner, m_last, m_v, m_src;
  logic [63:0] m_dp, m_dn;
  longint      m_cnt [2];
  bit          obs_r0, obs_r1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_last = 1;
    m_v = 0; m_src = 0; m_dp = '0; m_dn = '0;
    m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  task automatic check_outputs();
    chk("v_o", vo, m_v);
    chk("data_o", dout, m_dp);
    chk("src_o", src, m_src);
    chk("data_o_neg", ndout, m_dn);
    chk("v_o_neg", nvo, m_v);
`ifdef BSG_MUXI2_SCHED_STATS_EN
    chk("count0", c0, m_cnt[0]);
    chk("count1", c1, m_cnt[1]);
    chk("count1_neg", nc1, m_cnt[1]);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {v0, v1, lk, rdy} = '0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    check_outputs();
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, check readies, let the edge pass, check the slot.
  task automatic step(input bit a0, input logic [63:0] x0, input bit a1,
                      input logic [63:0] x1, input bit l, input bit rd);
    bit slot_free, who, take;
    v0 = a0; d0 = x0; v1 = a1; d1 = x1; lk = l; rdy = rd;
    #1;
    obs_r0 = r0; obs_r1 = r1;
    slot_free = !m_v || rd;
    take = 0;
    who  = 0;
    if (m_locked) begin
      who = m_owner;
      chk("ready0_locked", r0, slot_free && !m_owner);
      chk("ready1_locked", r1, slot_free && m_owner);
      take = slot_free && (who ? a1 : a0);
    end else if (a0 || a1) begin
      who = (a0 && a1) ? !m_last : a1;
      chk("ready0", r0, slot_free && !who);
      chk("ready1", r1, slot_free && who);
      take = slot_free;
    end else begin
      chk("ready_excl", r0 && r1, 0);
      chk("ready_gated", (r0 || r1) && !slot_free, 0);
    end
    chk("ready_neg_match", {nr0, nr1}, {r0, r1});
    @(posedge clk);
    #1;
    if (take) begin
      m_v  = 1;
      m_src = who;
      m_dp = who ? x1 : x0;
      m_dn = ~m_dp;
      m_last = who;
      if (m_cnt[who] < 64'hFFFF_FFFF) m_cnt[who]++;
      if (!m_locked && l) begin m_locked = 1; m_owner = who; end
      else if (m_locked && !l) m_locked = 0;
    end else if (rd) begin
      m_v = 0;
    end
    check_outputs();
    @(negedge clk);
  endtask

  int          seq [6];
  logic [63:0] held;

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    chk("rst_v_o", vo, 0);
    chk("rst_data_o", dout, 64'h0);
    chk("rst_src_o", src, 0);

    step(1, 64'h1234, 0, 64'h0, 0, 1);
    chk("first_ready0", obs_r0, 1);
    chk("first_data", dout, 64'h1234);
    chk("first_src", src, 0);

    // Round robin with both valid and the consumer always ready.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 64'(100 + i), 1, 64'(200 + i), 0, 1);
      seq[i] = int'(src);
      chk("rr_v", vo, 1);
    end
    for (int i = 0; i < 6; i++) chk("rr_src", 64'(seq[i]), 64'(i % 2));

    // Backpressure: slot holds, nobody is granted until ready_i rises.
    do_reset();
    step(1, 64'hAAAA_5555, 0, 64'h0, 0, 0);
    held = 64'hAAAA_5555;
    for (int i = 0; i < 5; i++) begin
      step(1, 64'(i), 1, 64'(i + 7), 0, 0);
      chk("bp_ready", {obs_r0, obs_r1}, 2'b00);
      chk("bp_data", dout, held);
    end
    step(1, 64'h11, 1, 64'h22, 0, 1);
    chk("bp_release_ready1", obs_r1, 1);
    chk("bp_release_data", dout, 64'h22);

    // Lock: requester 1 owns three beats while requester 0 waits.
    do_reset();
    step(1, 64'h5, 0, 64'h0, 0, 1);
    step(1, 64'h10, 1, 64'h20, 1, 1);
    seq[0] = int'(src);
    chk("lock_r0_a", obs_r0, 0);
    step(1, 64'h11, 1, 64'h21, 1, 1);
    seq[1] = int'(src);
    chk("lock_r0_b", obs_r0, 0);
    step(1, 64'h12, 1, 64'h22, 0, 1);
    seq[2] = int'(src);
    chk("lock_r0_c", obs_r0, 0);
    step(1, 64'h13, 1, 64'h23, 0, 1);
    seq[3] = int'(src);
    chk("lock_seq0", 64'(seq[0]), 1);
    chk("lock_seq1", 64'(seq[1]), 1);
    chk("lock_seq2", 64'(seq[2]), 1);
    chk("lock_seq3", 64'(seq[3]), 0);

    // Asynchronous reset mid-packet with a beat held.
    do_reset();
    step(1, 64'h1, 0, 64'h0, 0, 1);
    step(1, 64'h2, 1, 64'h3, 1, 0);
    step(1, 64'h4, 1, 64'h5, 1, 0);
    chk("pre_reset_v", vo, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_v", vo, 0);
    chk("async_reset_data", dout, 64'h0);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    step(1, 64'h77, 1, 64'h88, 0, 1);
    chk("post_reset_ready0", obs_r0, 1);
    chk("post_reset_src", src, 0);

    // Inverting polarity: zero in gives all ones out.
    do_reset();
    step(0, 64'h0, 1, 64'h0, 0, 1);
    chk("neg_all_ones", ndout, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef BSG_MUXI2_SCHED_STATS_EN
    chk("neg_count1", nc1, 32'd1);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, {$urandom, $urandom},
           $urandom_range(0, 3) != 0, {$urandom, $urandom},
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
